// File: rtl/am_audio_pkg.sv
// ----------------------------------------------------------------------------
// am_audio_pkg
//   Shared constants and helpers for the AM receiver audio back end.
//   - AUDIO_W / AUDIO_MAX / AUDIO_MIN : signed 16-bit audio sample range
//   - sat16()                         : clamp a wide signed value to 16 bits
//   - pwm_mid()                       : midscale duty for a given PWM width
// ----------------------------------------------------------------------------
package am_audio_pkg;

  localparam int AUDIO_W = 16;
  localparam logic signed [AUDIO_W-1:0] AUDIO_MAX = 16'sh7FFF;
  localparam logic signed [AUDIO_W-1:0] AUDIO_MIN = 16'sh8000;

  // Clamp a sign-extended 32-bit value into the signed 16-bit audio range.
  function automatic logic signed [AUDIO_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'(AUDIO_MAX))      return AUDIO_MAX;
    else if (v < 32'(AUDIO_MIN)) return AUDIO_MIN;
    else                         return v[AUDIO_W-1:0];
  endfunction

  // Midscale duty (50 %) for a PWM of the given resolution.
  function automatic int pwm_mid(input int pwm_w);
    return 1 << (pwm_w - 1);
  endfunction

endpackage

// File: rtl/am_audio_out_pwm_dac.sv
// ----------------------------------------------------------------------------
// pwm_dac
//   Free-running PWM audio DAC with a one-deep duty buffer. New duties are
//   only taken into use at the period wrap so every period is glitch-free.
//   Ports:
//     CLK, RST     clock, asynchronous active-high reset
//     duty_in      new duty value (offset binary)
//     duty_we      one-cycle write strobe for duty_in
//     pwm_out      registered PWM pin
//     overrun      sticky: a pending duty was overwritten before the wrap
//     overrun_clr  clears overrun (a simultaneous set wins)
// ----------------------------------------------------------------------------
module pwm_dac
  import am_audio_pkg::*;
#(
  parameter int PWM_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PWM_W-1:0] duty_in,
  input  logic             duty_we,
  output logic             pwm_out,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_MID = PWM_W'(pwm_mid(PWM_W));

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] pending_q, pending_d;
  logic [PWM_W-1:0] duty_act_q, duty_act_d;
  logic             pend_valid_q, pend_valid_d;
  logic             overrun_q, overrun_d;
  logic             pwm_q;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no latch is inferred.
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    duty_act_d   = duty_act_q;
    overrun_d    = overrun_q;

    if (duty_we) begin
      pending_d    = duty_in;
      pend_valid_d = 1'b1;
    end

    // A write landing on the wrap cycle bypasses the buffer and is used at once.
    if (wrap) begin
      if (duty_we)           duty_act_d = duty_in;
      else if (pend_valid_q) duty_act_d = pending_q;
      pend_valid_d = 1'b0;
    end

    // Clear first so that a coincident set overrides it.
    if (overrun_clr) overrun_d = 1'b0;
    if (duty_we && pend_valid_q && !wrap) overrun_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      pending_q    <= '0;
      duty_act_q   <= DUTY_MID;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + 1'b1;          // wraps naturally at 2^PWM_W
      pending_q    <= pending_d;
      duty_act_q   <= duty_act_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
      pwm_q        <= (cnt_q < duty_act_q);
    end
  end

  assign pwm_out = pwm_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/am_audio_out.sv
// ----------------------------------------------------------------------------
// am_audio_out
//   Audio back end of the 1-bit AM receiver: DC-blocking IIR, power-of-two
//   gain with saturation, and a PWM audio DAC.
//   Ports:
//     CLK, RST     clock, asynchronous active-high reset
//     demod_in     unsigned AM magnitude, valid when in_tick=1
//     in_tick      one-cycle input strobe (accepted every cycle)
//     gain         left shift 0..7 applied after DC removal
//     overrun_clr  clears the sticky overrun flag
//     audio_out    signed, DC-free, gained, saturated sample
//     audio_tick   one-cycle strobe, two clocks after in_tick
//     pwm_out      PWM audio pin
//     overrun      sticky duty-buffer overrun flag
// ----------------------------------------------------------------------------
module am_audio_out
  import am_audio_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int DC_SHIFT = 8,
  parameter int PWM_W    = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IN_W-1:0]           demod_in,
  input  logic                      in_tick,
  input  logic [2:0]                gain,
  input  logic                      overrun_clr,
  output logic signed [AUDIO_W-1:0] audio_out,
  output logic                      audio_tick,
  output logic                      pwm_out,
  output logic                      overrun
);

  localparam int ACC_W = IN_W + 1 + DC_SHIFT;  // holds DC * 2^DC_SHIFT
  localparam int Y_W   = IN_W + 2;             // x - DC spans +/- 2^IN_W
  localparam int G_W   = IN_W + 8;             // y shifted by up to 7

  // S1: DC tracker. acc converges to the input mean scaled by 2^DC_SHIFT.
  logic signed [IN_W:0]      x;
  logic signed [ACC_W-1:0]   acc_q, acc_d, dc;
  logic signed [Y_W-1:0]     y_d, y_q;
  logic                      s1_valid_q;

  assign x     = {1'b0, demod_in};
  assign dc    = acc_q >>> DC_SHIFT;
  assign y_d   = Y_W'(x) - Y_W'(dc);
  assign acc_d = acc_q + ACC_W'(y_d);

  // S2: gain and saturate.
  logic signed [G_W-1:0]     g;
  logic signed [AUDIO_W-1:0] audio_q;
  logic                      audio_tick_q;

  assign g = G_W'(y_q) <<< gain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q        <= '0;
      y_q          <= '0;
      s1_valid_q   <= 1'b0;
      audio_q      <= '0;
      audio_tick_q <= 1'b0;
    end else begin
      s1_valid_q   <= in_tick;
      audio_tick_q <= s1_valid_q;
      if (in_tick) begin
        acc_q <= acc_d;
        y_q   <= y_d;
      end
      if (s1_valid_q) audio_q <= sat16(32'(g));
    end
  end

  assign audio_out  = audio_q;
  assign audio_tick = audio_tick_q;

  // S3: offset-binary duty from the top PWM_W bits of the audio sample.
  logic [PWM_W-1:0] duty;
  assign duty = {~audio_q[AUDIO_W-1], audio_q[AUDIO_W-2:AUDIO_W-PWM_W]};

  pwm_dac #(.PWM_W(PWM_W)) u_pwm_dac (
    .CLK         (CLK),
    .RST         (RST),
    .duty_in     (duty),
    .duty_we     (audio_tick_q),
    .pwm_out     (pwm_out),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

endmodule

// File: tb/tb_am_audio_out.sv
// ----------------------------------------------------------------------------
// tb_am_audio_out
//   Self-checking bench for am_audio_out: table-driven single-sample vectors,
//   directed PWM / overrun / reset sequences, and randomized traffic compared
//   against an arithmetic reference model of the DC blocker and gain stage.
// ----------------------------------------------------------------------------
module tb_am_audio_out;

  logic               CLK = 1'b0;
  logic               RST;
  logic [15:0]        demod_in;
  logic               in_tick;
  logic [2:0]         gain;
  logic               overrun_clr;
  logic signed [15:0] audio_out;
  logic               audio_tick;
  logic               pwm_out;
  logic               overrun;

  always #5 CLK = ~CLK;

  am_audio_out dut (
    .CLK         (CLK),
    .RST         (RST),
    .demod_in    (demod_in),
    .in_tick     (in_tick),
    .gain        (gain),
    .overrun_clr (overrun_clr),
    .audio_out   (audio_out),
    .audio_tick  (audio_tick),
    .pwm_out     (pwm_out),
    .overrun     (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Elapsed clocks since reset, modulo the PWM period.
  int cnt_m;
  always @(posedge CLK or posedge RST) begin
    if (RST) cnt_m <= 0;
    else     cnt_m <= (cnt_m + 1) % 1024;
  end

  function automatic longint floor_div256(input longint a);
    if (a >= 0) return a / 256;
    else        return -((-a + 255) / 256);
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Duty in offset binary, 10-bit, truncated.
  function automatic longint duty_of(input longint a);
    return (a + 32768) / 64;
  endfunction

  longint acc_m;
  longint exp_q[$];
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_m <= 0;
      exp_q.delete();
    end else if (in_tick) begin
      longint y;
      y = longint'(demod_in) - floor_div256(acc_m);
      acc_m <= acc_m + y;
      exp_q.push_back(clamp16(y * (longint'(1) << gain)));
    end
  end

  bit     mono_mode = 1'b0;
  longint last_audio = 32767;
  int     mono_bad = 0;
  always @(negedge CLK) begin
    if (!RST && audio_tick) begin
      if (exp_q.size() == 0) check("unexpected_audio_tick", 1, 0);
      else                   check("audio_model", audio_out, exp_q.pop_front());
      if (mono_mode) begin
        if (audio_out > last_audio || audio_out < 0) mono_bad++;
        last_audio = audio_out;
      end
    end
  end

  // ---------------- helpers (called at a negedge) ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; in_tick = 1'b0; overrun_clr = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    demod_in = v; in_tick = 1'b1;
    @(negedge CLK);
    in_tick = 1'b0;
  endtask

  task automatic wait_cnt(input int c);
    int k = 0;
    while (cnt_m != c && k < 2048) begin
      @(negedge CLK);
      k++;
    end
    if (cnt_m != c) check("wait_cnt_timeout", cnt_m, c);
  endtask

  // High clocks in the first full period after the next wrap.
  task automatic count_period(output int highs);
    @(negedge CLK);
    wait_cnt(1);
    highs = 0;
    repeat (1024) begin
      highs += int'(pwm_out);
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [2:0]  g;
    longint      exp;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int highs;
    RST = 1'b1; in_tick = 1'b0; demod_in = '0; gain = '0; overrun_clr = 1'b0;

    vecs[0] = '{16'd100,   3'd0, 100};
    vecs[1] = '{16'h4000,  3'd0, 16384};
    vecs[2] = '{16'h4000,  3'd1, 32767};
    vecs[3] = '{16'h4000,  3'd7, 32767};
    vecs[4] = '{16'd0,     3'd5, 0};
    vecs[5] = '{16'hFFFF,  3'd0, 32767};
    vecs[6] = '{16'd1,     3'd7, 128};
    vecs[7] = '{16'd200,   3'd5, 6400};
    vecs[8] = '{16'h00FF,  3'd7, 32640};

    // 1: reset state and idle midscale PWM
    @(negedge CLK);
    check("rst_pwm", pwm_out, 0);
    check("rst_audio_tick", audio_tick, 0);
    do_reset();
    check("rst_audio", audio_out, 0);
    check("rst_overrun", overrun, 0);
    count_period(highs);
    check("idle_pwm_highs", highs, 512);
    check("idle_audio", audio_out, 0);
    check("idle_overrun", overrun, 0);

    // Single-sample vectors from a cleared accumulator, with latency checks.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      gain = vecs[i].g;
      send(vecs[i].din);
      check("lat_early", audio_tick, 0);
      @(negedge CLK);
      check("lat_tick", audio_tick, 1);
      check("vec_audio", audio_out, vecs[i].exp);
      @(negedge CLK);
      check("tick_one_cycle", audio_tick, 0);
      check("audio_hold", audio_out, vecs[i].exp);
    end

    // 2: DC decay at gain 0
    do_reset();
    gain = 3'd0;
    send(16'h4000);
    @(negedge CLK);
    check("decay_first", audio_out, 16384);
    repeat (2046) @(negedge CLK);
    send(16'h4000);
    @(negedge CLK);
    check("decay_second", audio_out, 16320);
    mono_mode = 1'b1;
    demod_in = 16'h4000; in_tick = 1'b1;
    repeat (4094) @(negedge CLK);
    in_tick = 1'b0;
    repeat (4) @(negedge CLK);
    mono_mode = 1'b0;
    check("decay_monotonic", mono_bad, 0);
    check("decay_final", audio_out, 0);

    // 3: saturation at gain 7 drives full-scale duty
    do_reset();
    gain = 3'd7;
    wait_cnt(200);
    send(16'h4000);
    @(negedge CLK);
    check("sat_audio", audio_out, 32767);
    wait_cnt(1023);
    count_period(highs);
    check("sat_pwm_highs", highs, 1023);

    // 4: two writes in one period -> overrun, newest duty wins
    do_reset();
    gain = 3'd0;
    wait_cnt(98);
    send(16'h4000);
    repeat (9) @(negedge CLK);
    send(16'd0);
    repeat (4) @(negedge CLK);
    check("overrun_set", overrun, 1);
    count_period(highs);
    check("overrun_newest_duty", highs, duty_of(-64));
    check("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge CLK);
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    // Set and clear in the same cycle: set wins.
    wait_cnt(300);
    send(16'h1000);
    wait_cnt(310);
    send(16'h2000);
    wait_cnt(312);
    overrun_clr = 1'b1;
    @(negedge CLK);
    overrun_clr = 1'b0;
    check("overrun_set_wins", overrun, 1);

    // 5: write landing on the wrap cycle is used in the very next period
    do_reset();
    gain = 3'd0;
    wait_cnt(1021);
    send(16'h4000);
    count_period(highs);
    check("wrap_write_duty", highs, duty_of(16384));
    check("wrap_write_no_overrun", overrun, 0);

    // 6: asynchronous reset mid-period with state nonzero
    do_reset();
    gain = 3'd0;
    wait_cnt(400);
    send(16'h4000);
    send(16'h1234);
    repeat (5) @(negedge CLK);
    check("pre_rst_overrun", overrun, 1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_audio", audio_out, 0);
    check("async_rst_tick", audio_tick, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_overrun", overrun, 0);
    @(negedge CLK);
    RST = 1'b0;
    send(16'd100);
    @(negedge CLK);
    check("post_rst_audio", audio_out, 100);

    // Randomized traffic against the reference model.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      gain = 3'($urandom_range(0, 7));
      for (int c = 0; c < 150; c++) begin
        in_tick = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       demod_in = 16'hFFFF;
          1:       demod_in = 16'h0000;
          default: demod_in = 16'($urandom);
        endcase
        @(negedge CLK);
      end
      in_tick = 1'b0;
      repeat (3) @(negedge CLK);
    end
    check("model_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
